mem_sweep_ctrl: RTL and testbench

- Sweep controller that sits directly upstream of the 4096x18 init-loaded block RAM and owns all of its ports: raddr, waddr, din, and it consumes dout.
- Three functions:
  - Fill: writes a deterministic pattern into every word.
  - Readback: computes a 32-bit checksum over all words without altering them.
  - Verify: readback plus a compare against the fill pattern, counting mismatches.
- Used to confirm memory contents after a bitstream-based reinit.
- The RAM writes every cycle (no write enable), so outside Fill this block keeps every write an exact write-back of the data just read.

---
 rtl/mem_sweep_pkg.sv | 27 ++
 rtl/mem_sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the block-RAM sweep controller.
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FILL,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] MODE_READBACK = 2'd0;
  localparam logic [1:0] MODE_FILL     = 2'd1;
  localparam logic [1:0] MODE_VERIFY   = 2'd2;

  // Rotate-left-by-one then XOR in the (zero-extended) data word.
  function automatic logic [31:0] csum_update(input logic [31:0] csum,
                                              input logic [31:0] word);
    return {csum[30:0], csum[31]} ^ word;
  endfunction

  // Fill/verify pattern; the caller truncates to the RAM word width.
  function automatic logic [31:0] pattern(input logic [31:0] seed,
                                          input logic [31:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/mem_sweep_ctrl.sv
// Sweep controller owning all ports of a write-every-cycle block RAM:
// fill with a pattern, checksum readback, or verify against the pattern.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 18,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [WID_MEM-1:0]  seed,
  output logic                busy,
  output logic                done,
  output logic [31:0]         checksum,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [WID_MEM-1:0]  mem_din,
  input  logic [WID_MEM-1:0]  mem_dout
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH_MEM - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   raddr_d;
  logic [WID_MEM-1:0]  seed_q;
  logic [1:0]          mode_q;
  logic                valid;
  logic [WID_MEM-1:0]  fill_word;
  logic [WID_MEM-1:0]  expect_word;

  assign fill_word   = WID_MEM'(pattern(32'(seed_q), 32'(cnt)));
  assign expect_word = WID_MEM'(pattern(32'(seed_q), 32'(raddr_d)));

  // Read address of the previous cycle; pairs with mem_dout for write-back.
  always_ff @(posedge clk) begin
    raddr_d <= mem_raddr;
  end

  // Outside FILL every write restores the word just read, so contents never change.
  always_comb begin
    mem_waddr = raddr_d;
    mem_din   = mem_dout;
    if (state == ST_FILL) begin
      mem_waddr = cnt;
      mem_din   = fill_word;
    end
  end

  // Sweep FSM with registered outputs plus checksum/mismatch accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      err_count <= '0;
      mem_raddr <= '0;
      valid     <= 1'b0;
    end else begin
      done  <= 1'b0;
      valid <= (state == ST_READ);

      if (valid) begin
        checksum <= csum_update(checksum, 32'(mem_dout));
        if (mode_q == MODE_VERIFY && mem_dout != expect_word) begin
          err_count <= err_count + (ADDR_W+1)'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          mem_raddr <= '0;
          if (start) begin
            seed_q    <= seed;
            mode_q    <= mode;
            checksum  <= '0;
            err_count <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= (mode == MODE_FILL) ? ST_FILL : ST_READ;
          end
        end

        ST_READ: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == CNT_LAST) begin
            mem_raddr <= '0;
            state     <= ST_DRAIN;
          end else begin
            mem_raddr <= cnt + ADDR_W'(1);
          end
        end

        ST_DRAIN: begin
          mem_raddr <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end

        ST_FILL: begin
          mem_raddr <= '0;
          cnt       <= cnt + ADDR_W'(1);
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a read-first, write-every-cycle RAM model.
module tb_mem_sweep_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [17:0] seed = '0;
  logic        busy, done;
  logic [31:0] checksum;
  logic [12:0] err_count;
  logic [11:0] mem_raddr, mem_waddr;
  logic [17:0] mem_din, mem_dout;

  logic [17:0] ram  [DEPTH];
  logic [17:0] img  [DEPTH];
  logic [17:0] snap [DEPTH];
  logic        load_en = 1'b0;
  logic [17:0] ram_dout;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  mem_sweep_ctrl #(.WID_MEM(18), .DEPTH_MEM(4096), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .checksum(checksum), .err_count(err_count),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  assign mem_dout = ram_dout;

  // RAM model: one-cycle read latency, read-first, writes every cycle; bench preload overrides.
  always @(posedge clk) begin
    ram_dout <= ram[mem_raddr];
    ram[mem_waddr] <= mem_din;
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= img[i];
      ram_dout <= img[mem_raddr];
    end
  end

  // Count done pulses.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [31:0] model_csum();
    logic [31:0] c = '0;
    for (int i = 0; i < DEPTH; i++) c = {c[30:0], c[31]} ^ {14'd0, snap[i]};
    return c;
  endfunction

  function automatic int diff_vs_snap();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== snap[i]) n++;
    return n;
  endfunction

  task automatic load_image(input int salt);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      img[i]  = 18'($urandom) ^ 18'(salt);
      snap[i] = img[i];
    end
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n0, output int lat);
    lat = n0;
    while (done !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [17:0] s, output int lat);
    @(negedge clk);
    start = 1'b1; mode = m; seed = s;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (checksum !== 32'd0) begin failures++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
    checks++; if (err_count !== 13'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    checks++; if (mem_raddr !== 12'd0) begin failures++; $display("FAIL reset_raddr got=%h exp=0", mem_raddr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_readback();
    int lat;
    logic [31:0] exp_c;
    load_image(32'h15a);
    exp_c = model_csum();
    run_op(2'd0, 18'h0, lat);
    exp_done++;
    checks++; if (lat != 4098) begin failures++; $display("FAIL rb_latency got=%0d exp=4098", lat); end
    checks++; if (checksum !== exp_c) begin failures++; $display("FAIL rb_checksum got=%h exp=%h", checksum, exp_c); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rb_done_width got=%0b exp=0", done); end
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL rb_ram_unchanged got=%0d exp=0", diff_vs_snap()); end
    run_op(2'd3, 18'h0, lat);
    exp_done++;
    checks++; if (checksum !== exp_c) begin failures++; $display("FAIL rb2_checksum got=%h exp=%h", checksum, exp_c); end
    checks++; if (err_count !== 13'd0) begin failures++; $display("FAIL rb2_err got=%0d exp=0", err_count); end
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL rb2_ram_unchanged got=%0d exp=0", diff_vs_snap()); end
  endtask

  task automatic test_fill_verify();
    int lat;
    int bad;
    logic [31:0] exp_c;
    run_op(2'd1, 18'h00005, lat);
    exp_done++;
    checks++; if (lat != 4097) begin failures++; $display("FAIL fill_latency got=%0d exp=4097", lat); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fill_done_width got=%0b/%0b exp=0/0", done, busy); end
    checks++; if (ram[255] !== 18'h00104) begin failures++; $display("FAIL fill_word_ff got=%h exp=00104", ram[255]); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      snap[i] = 18'(5 + i);
      if (ram[i] !== snap[i]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fill_all_words got=%0d_bad exp=0", bad); end
    exp_c = model_csum();
    run_op(2'd2, 18'h00005, lat);
    exp_done++;
    checks++; if (lat != 4098) begin failures++; $display("FAIL verify_latency got=%0d exp=4098", lat); end
    checks++; if (err_count !== 13'd0) begin failures++; $display("FAIL verify_err_match got=%0d exp=0", err_count); end
    checks++; if (checksum !== exp_c) begin failures++; $display("FAIL verify_checksum got=%h exp=%h", checksum, exp_c); end
    run_op(2'd2, 18'h00006, lat);
    exp_done++;
    checks++; if (err_count !== 13'd4096) begin failures++; $display("FAIL verify_err_all got=%0d exp=4096", err_count); end
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL verify_ram_kept got=%0d exp=0", diff_vs_snap()); end
  endtask

  task automatic test_reset_read();
    load_image(32'h2c3);
    @(negedge clk);
    start = 1'b1; mode = 2'd0; seed = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (mem_raddr !== 12'd100 || busy !== 1'b1) begin failures++; $display("FAIL rr_pre got=%h/%0b exp=064/1", mem_raddr, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rr_busy_done got=%0b/%0b exp=0/0", busy, done); end
    checks++; if (checksum !== 32'd0) begin failures++; $display("FAIL rr_checksum got=%h exp=0", checksum); end
    checks++; if (mem_raddr !== 12'd0) begin failures++; $display("FAIL rr_raddr got=%h exp=0", mem_raddr); end
    repeat (4) @(negedge clk);
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL rr_ram_unchanged got=%0d exp=0", diff_vs_snap()); end
  endtask

  task automatic test_reset_fill();
    int bad_lo;
    int bad_hi;
    logic [17:0] e;
    load_image(32'h3d1);
    @(negedge clk);
    start = 1'b1; mode = 2'd1; seed = 18'h3FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (mem_waddr !== 12'd10 || mem_din !== 18'h00009) begin failures++; $display("FAIL rf_pre got=%h/%h exp=00a/00009", mem_waddr, mem_din); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rf_busy_done got=%0b/%0b exp=0/0", busy, done); end
    repeat (4) @(negedge clk);
    checks++; if (ram[1] !== 18'h00000) begin failures++; $display("FAIL rf_addr1 got=%h exp=00000", ram[1]); end
    bad_lo = 0;
    bad_hi = 0;
    for (int i = 0; i < DEPTH; i++) begin
      e = (i <= 10) ? 18'(18'h3FFFF + i) : snap[i];
      if (ram[i] !== e) begin
        if (i <= 10) bad_lo++; else bad_hi++;
      end
    end
    checks++; if (bad_lo != 0) begin failures++; $display("FAIL rf_filled_part got=%0d_bad exp=0", bad_lo); end
    checks++; if (bad_hi != 0) begin failures++; $display("FAIL rf_untouched_part got=%0d_bad exp=0", bad_hi); end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [31:0] exp_c;
    load_image(32'h0e7);
    exp_c = model_csum();
    @(negedge clk);
    start = 1'b1; mode = 2'd0; seed = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1; mode = 2'd1; seed = 18'h12345;
    @(negedge clk);
    start = 1'b0;
    wait_done(51, lat);
    exp_done++;
    checks++; if (lat != 4098) begin failures++; $display("FAIL busy_start_latency got=%0d exp=4098", lat); end
    checks++; if (checksum !== exp_c) begin failures++; $display("FAIL busy_start_checksum got=%h exp=%h", checksum, exp_c); end
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL busy_start_ram got=%0d exp=0", diff_vs_snap()); end
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mode = 2'd1; seed = 18'h0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_busy got=%0b exp=0", busy); end
    checks++; if (diff_vs_snap() != 0) begin failures++; $display("FAIL reset_start_ram got=%0d exp=0", diff_vs_snap()); end
  endtask

  task automatic test_done_count();
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != exp_done) begin failures++; $display("FAIL done_count got=%0d exp=%0d", done_cnt, exp_done); end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_fill_verify();
    test_reset_read();
    test_reset_fill();
    test_start_ignored();
    test_done_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
